// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: two-stage registered Booth multiply feeding a saturating/wrapping
// signed accumulator that presents each completed run on a valid/ready output.
module Bit16Radix4BoothMultiplier (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);
  logic [16:0] bx;
  assign bx = {b_i, 1'b0};
  function automatic logic signed [31:0] pp(input logic [2:0] t, input logic signed [31:0] m);
    return (t == 3'b011) ? m <<< 1 :
           (t == 3'b100) ? -(m <<< 1) :
           (t == 3'b001 || t == 3'b010) ? m :
           (t == 3'b101 || t == 3'b110) ? -m : 32'sd0;
  endfunction
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 8; i++) p_o = p_o + (pp(bx[2*i+:3], 32'(a_i)) <<< (2*i));
  end
endmodule

module booth_mac_accumulator #(
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      a,
  input  logic signed [15:0]      b,
  input  logic                    last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    overflow,
  output logic [7:0]              terms
);
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  state_t                  state_q, state_d;
  logic signed [15:0]      a_q, b_q;
  logic                    last1_q, v1_q, last2_q, v2_q;
  logic signed [31:0]      prod, p_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, clamp;
  logic                    ovf_q, ovf_d, accept, hs, sum_ovf;
  logic [7:0]              terms_q, terms_d;
  logic signed [ACC_W:0]   sum;
  Bit16Radix4BoothMultiplier u_mul (.a_i(a_q), .b_i(b_q), .p_o(prod));
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == HOLD;
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign terms     = terms_q;
  // One guard bit: the two top bits of the widened sum disagree exactly on overflow.
  assign sum     = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(p_q);
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign clamp   = SATURATE ? (sum[ACC_W] ? MIN_V : MAX_V) : sum[ACC_W-1:0];
  always_comb begin
    acc_d   = hs ? '0 : v2_q ? (sum_ovf ? clamp : sum[ACC_W-1:0]) : acc_q;
    ovf_d   = hs ? 1'b0 : ovf_q | (v2_q & sum_ovf);
    terms_d = hs ? 8'd0 : (v2_q && terms_q != 8'hFF) ? terms_q + 8'd1 : terms_q;
    state_d = (state_q == ACC)   ? ((accept && last) ? DRAIN : ACC) :
              (state_q == DRAIN) ? ((v2_q && last2_q) ? HOLD : DRAIN) :
              (state_q == HOLD)  ? (out_ready ? ACC : HOLD) : ACC;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      a_q     <= '0;
      b_q     <= '0;
      last1_q <= 1'b0;
      v1_q    <= 1'b0;
      p_q     <= '0;
      last2_q <= 1'b0;
      v2_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      terms_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        last1_q <= last;
      end
      v1_q    <= accept;
      p_q     <= prod;
      last2_q <= last1_q;
      v2_q    <= v1_q;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      terms_q <= terms_d;
    end
  end
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator: directed runs checked by a cycle-level arithmetic model (40-bit,
// saturating instance) plus literal expectations, including 32-bit saturate/wrap instances.
module tb_booth_mac_accumulator;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, last = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, overflow;
  logic [39:0] acc_out;
  logic [7:0] terms;
  logic s_in_ready, s_out_valid, s_overflow, w_in_ready, w_out_valid, w_overflow;
  logic [31:0] s_acc, w_acc;
  logic [7:0] s_terms, w_terms;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator u40 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .last(last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .terms(terms));
  booth_mac_accumulator #(.ACC_W(32), .SATURATE(1'b1)) u32s (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .last(last),
    .out_valid(s_out_valid), .out_ready(out_ready), .acc_out(s_acc), .overflow(s_overflow),
    .terms(s_terms));
  booth_mac_accumulator #(.ACC_W(32), .SATURATE(1'b0)) u32w (.clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w_in_ready), .a(a), .b(b), .last(last),
    .out_valid(w_out_valid), .out_ready(out_ready), .acc_out(w_acc), .overflow(w_overflow),
    .terms(w_terms));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: each accepted product lands in the sum two edges later.
  typedef struct {longint p; bit l; int due;} beat_t;
  localparam longint MAX40 = (64'sd1 <<< 39) - 1;
  localparam longint MIN40 = -(64'sd1 <<< 39);
  beat_t q[$];
  longint acc_m = 0, s;
  int terms_m = 0, edge_n = 0;
  bit ovf_m = 0, hold_m = 0, inflight = 0, acc_s = 0, hs_s = 0, last_s = 0, rst_seen = 0;
  shortint a_s = 0, b_s = 0;

  always @(posedge rst) rst_seen = 1;

  always @(negedge clk) begin
    if (rst || rst_seen) begin
      q.delete();
      acc_m = 0; terms_m = 0; ovf_m = 0; hold_m = 0; inflight = 0;
      rst_seen = rst;
    end else begin
      edge_n++;
      if (hs_s) begin acc_m = 0; terms_m = 0; ovf_m = 0; hold_m = 0; end
      if (acc_s) begin
        q.push_back('{p: longint'(a_s) * longint'(b_s), l: last_s, due: edge_n + 2});
        if (last_s) inflight = 1;
      end
      while (q.size() > 0 && q[0].due == edge_n) begin
        s = acc_m + q[0].p;
        if (s > MAX40 || s < MIN40) begin ovf_m = 1; s = (s > MAX40) ? MAX40 : MIN40; end
        acc_m = s;
        if (terms_m < 255) terms_m++;
        if (q[0].l) begin hold_m = 1; inflight = 0; end
        void'(q.pop_front());
      end
    end
    chk("m_out_valid", 64'(out_valid), 64'(hold_m));
    chk("m_in_ready", 64'(in_ready), 64'(!(inflight || hold_m)));
    chk("m_acc_out", 64'(acc_out), 64'(acc_m[39:0]));
    chk("m_terms", 64'(terms), 64'(terms_m));
    chk("m_overflow", 64'(overflow), 64'(ovf_m));
    acc_s = in_valid && !(inflight || hold_m) && !rst;
    hs_s = hold_m && out_ready;
    a_s = a; b_s = b; last_s = last;
  end

  task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic l);
    int n = 0;
    in_valid = 1; a = x; b = y; last = l;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (n == 50) chk("beat_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    in_valid = 0; last = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_acc", 64'(acc_out), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_terms", 64'(terms), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    beat(16'h0001, 16'h0001, 1);
    wait_out(n);
    chk("single_latency", 64'(n), 64'd2);
    chk("single_acc", 64'(acc_out), 64'd1);
    chk("single_terms", 64'(terms), 64'd1);
    chk("single_ovf", 64'(overflow), 64'd0);
    handshake();

    beat(16'hFFFF, 16'h0001, 0);
    beat(16'hFFFF, 16'hFFFF, 0);
    beat(16'h1234, 16'hFEDC, 1);
    wait_out(n);
    chk("mixed_acc", 64'(acc_out), 64'h00FFFFEB3CB0);
    chk("mixed_terms", 64'(terms), 64'd3);
    chk("mixed_ovf", 64'(overflow), 64'd0);
    handshake();

    beat(16'h8000, 16'h8000, 0);
    beat(16'h8000, 16'h8000, 1);
    wait_out(n);
    chk("sat32_acc", 64'(s_acc), 64'h7FFFFFFF);
    chk("sat32_ovf", 64'(s_overflow), 64'd1);
    chk("wrap32_acc", 64'(w_acc), 64'h80000000);
    chk("wrap32_ovf", 64'(w_overflow), 64'd1);
    chk("wrap32_out_valid", 64'(w_out_valid), 64'd1);
    chk("acc40_no_ovf", 64'(acc_out), 64'h0080000000);
    chk("acc40_ovf", 64'(overflow), 64'd0);
    handshake();
    chk("sat32_ovf_cleared", 64'(s_overflow), 64'd0);

    beat(16'd3, 16'd4, 0);
    beat(16'd5, 16'd6, 1);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 16'h0100 + 16'(i); b = 16'd9; last = (i == 4);
      @(posedge clk); #2;
      chk("bp_acc", 64'(acc_out), 64'd42);
      chk("bp_terms", 64'(terms), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 0; last = 0;
    handshake();
    beat(16'd1, 16'd7, 1);
    wait_out(n);
    chk("bp_fresh_acc", 64'(acc_out), 64'd7);
    chk("bp_fresh_terms", 64'(terms), 64'd1);
    handshake();

    for (int i = 0; i < 260; i++) beat(16'd1, 16'd1, i == 259);
    wait_out(n);
    chk("terms_sat", 64'(terms), 64'd255);
    chk("terms_sat_acc", 64'(acc_out), 64'd260);
    handshake();

    beat(16'd5, 16'd5, 0);
    beat(16'd7, 16'd7, 1);
    @(posedge clk); #3;
    chk("pre_rst_acc", 64'(acc_out), 64'd25);
    rst = 1;
    #1;
    chk("async_rst_acc", 64'(acc_out), 64'd0);
    chk("async_rst_terms", 64'(terms), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #1;
    rst = 0;
    repeat (6) begin
      @(posedge clk); #2;
      chk("no_out_after_rst", 64'(out_valid), 64'd0);
    end
    beat(16'd2, 16'd3, 1);
    wait_out(n);
    chk("after_rst_latency", 64'(n), 64'd2);
    chk("after_rst_acc", 64'(acc_out), 64'd6);
    handshake();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
